decoder3to8_seq: RTL and testbench
==================================

# decoder3to8_seq

Sequenced 3-to-8 decoder: the receiving end of the 8-to-3 priority encoder's `{Y, V}` output. Each accepted 3-bit index becomes a registered one-hot strobe on an 8-line output bus. The strobe is held for a fixed number of cycles, followed by an optional all-zero gap. A one-entry buffer with a ready handshake allows back-to-back indices without loss.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot strobe is driven; legal range ≥1.
- `GAP_CYCLES`, default 1: all-zero cycles after each strobe; legal range ≥0.
- `clk` input, 1 bit: single clock, all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `Y` input, 3 bits: encoded line index, 0..7.
- `V` input, 1 bit: index valid.
- `ready` output, 1 bit: block can accept; equals NOT buffer-full.
- `D` output, 8 bits: registered one-hot decode, `D[Y]` = 1.
- `busy` output, 1 bit: high in DRIVE or GAP.
- `done` output, 1 bit: high during the final DRIVE cycle of each strobe.

## Operation
- States:
  - IDLE: `D` = 0.
  - DRIVE: `D` = one-hot of the current index.
  - GAP: `D` = 0.
- Accept occurs when `V && ready` at a rising edge. `Y` is sampled only on accept.
- Accept in IDLE loads the drive register directly and moves to DRIVE. The buffer stays empty.
- Accept in DRIVE or GAP stores `Y` in the buffer, which becomes full; `ready` = 0.
- DRIVE lasts exactly `HOLD_CYCLES` cycles, tracked by a down-counter sized `$clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1)`.
- At DRIVE end:
  - `GAP_CYCLES` > 0: go to GAP for exactly `GAP_CYCLES` cycles.
  - Otherwise: take the "next" decision below immediately.
- Next decision, at the end of GAP or at the end of DRIVE when the gap is zero:
  - Buffer full: load the buffer into the drive register, go to DRIVE, buffer empties.
  - Buffer empty and accept on this same edge: bypass the buffer and go to DRIVE with the new `Y`.
  - Otherwise: go to IDLE.
- Only one of {buffer load, new accept} can occur per edge. `ready` = 0 while the buffer is full, so a third index is never taken.
- `D` is always one-hot or zero, never multi-hot. Exception: the `DEC_ACTIVE_LOW_EN` inversion, which is one-cold or all-ones.

## Timing
- Reset (asynchronous, immediate): state IDLE, buffer empty, `D` = 8'h00 (8'hFF with `DEC_ACTIVE_LOW_EN`), `ready` = 1, `busy` = 0, `done` = 0.
- Latency: the edge that samples an accept in IDLE also updates `D`. The strobe is visible for the following `HOLD_CYCLES` clock periods.
- `busy` and `D` change on the same edges.
- `done` is asserted together with the last DRIVE cycle's `D`.
- Back-to-back throughput: one strobe every `HOLD_CYCLES` + `GAP_CYCLES` cycles. With a zero gap, consecutive strobes are contiguous, and `D` switches lines in one edge with no zero cycle.
- `ready` rises the cycle after the buffer is drained into DRIVE.
- Reset mid-strobe: `D` returns to the idle value immediately. The buffered index is discarded, and no `done` is emitted.
- `V` asserted in IDLE while in reset: ignored. The first accept occurs at the first edge after `rst` falls.

## Configuration
- `DEC_ACTIVE_LOW_EN`:
  - Defined: `D` is the bitwise inverse (idle/gap/reset = 8'hFF, active line 0). `ready`, `busy` and `done` are unaffected.
  - Undefined: active-high `D` as described above.

## Test plan
All scenarios use `HOLD_CYCLES` = 4 and `GAP_CYCLES` = 1 unless noted.
- Reset behaviour: assert `rst` mid-cycle with `V` = 1 → `D` = 00, `ready` = 1, `busy` = 0 immediately; no strobe after release until a new accept.
- Single strobe: `Y` = 5, `V` = 1 for one cycle from IDLE → `D` = 8'b0010_0000 for exactly 4 cycles, `done` on the 4th, then 1 cycle of 00, then IDLE.
- Sweep: indices 0..7 each sent after IDLE → `D` equals 1<<`Y` each time; never multi-hot.
- Back-to-back: `Y` = 1 then `Y` = 6 held valid → second index buffered, `ready` = 0 until the buffer loads; `D` sequence is 02×4, 00×1, 40×4; no loss, no duplication.
- Zero gap (`GAP_CYCLES` = 0): 3 queued indices 7, 0, 3 → `D` 80×4, 01×4, 08×4 contiguous; three `done` pulses, 4 cycles apart.
- Reset mid-operation: `rst` during the 2nd DRIVE cycle with the buffer full → all outputs return to reset values immediately; the buffered index is never driven. Repeat with `DEC_ACTIVE_LOW_EN`: idle `D` = FF, `Y` = 2 yields FB.

Source files
------------

// File: rtl/decoder3to8_seq_if.sv
// decoder3to8_seq_if: index handshake and strobe bus of decoder3to8_seq.
// master drives Y/V and observes ready/D/busy/done; slave is the decoder side.
interface decoder3to8_seq_if;
  logic [2:0] Y;
  logic       V;
  logic       ready;
  logic [7:0] D;
  logic       busy;
  logic       done;

  modport master (
    output Y, V,
    input  ready, D, busy, done
  );

  modport slave (
    input  Y, V,
    output ready, D, busy, done
  );
endinterface

// File: rtl/decoder3to8_seq.sv
// decoder3to8_seq: sequenced 3-to-8 decoder, one-hot strobe held HOLD_CYCLES
// then GAP_CYCLES of zero; one-entry buffer behind a ready handshake.
// Ports: clk, rst (async active-high), bus (slave: Y,V in; ready,D,busy,done out).
// Option: define DEC_ACTIVE_LOW_EN to drive D inverted (idle 8'hFF).
module decoder3to8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst,
  decoder3to8_seq_if.slave   bus
);

  localparam int MAXC =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD =
    (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [7:0] D_POL = 8'hFF;
`else
  localparam logic [7:0] D_POL = 8'h00;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [2:0]    r_buf;
  logic          r_full;
  logic [7:0]    r_d;
  logic          r_busy;
  logic          r_done;

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic [2:0]    w_idx;
  logic [2:0]    w_buf;
  logic          w_full;
  logic          w_accept;
  logic [7:0]    w_dec;

  assign w_accept = bus.V && !r_full;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_buf   = r_buf;
    w_full  = r_full;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state = S_DRIVE;
          w_cnt   = HOLD_LD;
          w_idx   = bus.Y;
        end
      end
      S_DRIVE, S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
          if (w_accept) begin
            w_buf  = bus.Y;
            w_full = 1'b1;
          end
        end else if (r_state == S_DRIVE && GAP_CYCLES > 0) begin
          w_state = S_GAP;
          w_cnt   = GAP_LD;
          if (w_accept) begin
            w_buf  = bus.Y;
            w_full = 1'b1;
          end
        end else if (r_full) begin
          // buffered index wins; ready is low so no new accept here
          w_state = S_DRIVE;
          w_cnt   = HOLD_LD;
          w_idx   = r_buf;
          w_full  = 1'b0;
        end else if (w_accept) begin
          w_state = S_DRIVE;
          w_cnt   = HOLD_LD;
          w_idx   = bus.Y;
        end else begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign w_dec = (w_state == S_DRIVE) ? (8'b1 << w_idx) : 8'h00;

  // outputs are registered from next-state so D/busy/done move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_d     <= D_POL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_buf   <= w_buf;
      r_full  <= w_full;
      r_d     <= w_dec ^ D_POL;
      r_busy  <= (w_state != S_IDLE);
      r_done  <= (w_state == S_DRIVE) && (w_cnt == '0);
    end
  end

  assign bus.ready = ~r_full;
  assign bus.D     = r_d;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_decoder3to8_seq.sv
// tb_decoder3to8_seq: directed checks of decoder3to8_seq.
// DUT a uses HOLD=4/GAP=1; DUT z uses HOLD=4/GAP=0.
module tb_decoder3to8_seq;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decoder3to8_seq_if a ();
  decoder3to8_seq_if z ();

  decoder3to8_seq #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES(1)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .bus(a)
  );

  decoder3to8_seq #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES(0)
  ) u_z (
    .clk(clk),
    .rst(rst),
    .bus(z)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a.V = 1'b1;
    a.Y = 3'd3;
    tick();
    total++;
    if (a.D !== (8'h08 ^ POL)) begin
      bad++;
      $display("FAIL rst_pre D got=%h exp=%h", a.D, 8'h08 ^ POL);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (a.D !== POL || a.ready !== 1'b1 || a.busy !== 1'b0 ||
        a.done !== 1'b0) begin
      bad++;
      $display("FAIL rst_now D=%h rdy=%b busy=%b done=%b exp D=%h 1 0 0",
               a.D, a.ready, a.busy, a.done, POL);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (a.D !== POL || a.busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_hold%0d D=%h busy=%b exp D=%h 0",
                 k, a.D, a.busy, POL);
      end
    end
    a.V = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (a.D !== POL || a.busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_rel%0d D=%h busy=%b exp D=%h 0",
                 k, a.D, a.busy, POL);
      end
    end
    a.V = 1'b1;
    a.Y = 3'd3;
    tick();
    a.V = 1'b0;
    total++;
    if (a.D !== (8'h08 ^ POL)) begin
      bad++;
      $display("FAIL rst_first D got=%h exp=%h", a.D, 8'h08 ^ POL);
    end
    repeat (6) tick();
  endtask

  task automatic test_single;
    logic [7:0] ed [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    logic       eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    a.V = 1'b1;
    a.Y = 3'd5;
    for (int k = 0; k < 6; k++) begin
      tick();
      a.V = 1'b0;
      total++;
      if (a.D !== (ed[k] ^ POL) || a.done !== eo[k] ||
          a.busy !== eb[k]) begin
        bad++;
        $display("FAIL single c%0d D=%h done=%b busy=%b exp %h %b %b",
                 k, a.D, a.done, a.busy, ed[k] ^ POL, eo[k], eb[k]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [7:0] exp;
    logic [7:0] act;
    for (int i = 0; i < 8; i++) begin
      exp = 8'b1 << i;
      a.V = 1'b1;
      a.Y = 3'(i);
      tick();
      a.V = 1'b0;
      act = a.D ^ POL;
      total++;
      if (a.D !== (exp ^ POL) || $countones(act) != 1) begin
        bad++;
        $display("FAIL sweep y%0d D=%h exp=%h", i, a.D, exp ^ POL);
      end
      repeat (4) tick();
      total++;
      if (a.D !== POL) begin
        bad++;
        $display("FAIL sweep_gap y%0d D=%h exp=%h", i, a.D, POL);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ed [11] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h40,
                            8'h40, 8'h40, 8'h40, 8'h00, 8'h00};
    logic       er [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    a.V = 1'b1;
    a.Y = 3'd1;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) a.Y = 3'd6;
      if (k == 2) a.V = 1'b0;
      tick();
      total++;
      if (a.D !== (ed[k] ^ POL) || a.ready !== er[k]) begin
        bad++;
        $display("FAIL b2b c%0d D=%h rdy=%b exp %h %b",
                 k, a.D, a.ready, ed[k] ^ POL, er[k]);
      end
    end
  endtask

  task automatic test_zero_gap;
    logic [7:0] ed [13] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01,
                            8'h01, 8'h01, 8'h08, 8'h08, 8'h08, 8'h08,
                            8'h00};
    logic       eo [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    z.V = 1'b1;
    z.Y = 3'd7;
    for (int k = 0; k < 13; k++) begin
      if (k == 1) z.Y = 3'd0;
      if (k == 2) z.Y = 3'd3;
      if (k == 6) z.V = 1'b0;
      tick();
      total++;
      if (z.D !== (ed[k] ^ POL) || z.done !== eo[k]) begin
        bad++;
        $display("FAIL zgap c%0d D=%h done=%b exp %h %b",
                 k, z.D, z.done, ed[k] ^ POL, eo[k]);
      end
    end
  endtask

  task automatic test_reset_midop;
    a.V = 1'b1;
    a.Y = 3'd2;
    tick();
    total++;
    if (a.D !== (8'h04 ^ POL)) begin
      bad++;
      $display("FAIL mid_first D got=%h exp=%h", a.D, 8'h04 ^ POL);
    end
    a.Y = 3'd6;
    tick();
    a.V = 1'b0;
    total++;
    if (a.D !== (8'h04 ^ POL) || a.ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_buf D=%h rdy=%b exp %h 0",
               a.D, a.ready, 8'h04 ^ POL);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (a.D !== POL || a.ready !== 1'b1 || a.busy !== 1'b0 ||
        a.done !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst D=%h rdy=%b busy=%b done=%b exp D=%h 1 0 0",
               a.D, a.ready, a.busy, a.done, POL);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (a.D !== POL || a.busy !== 1'b0 || a.done !== 1'b0) begin
        bad++;
        $display("FAIL mid_after%0d D=%h busy=%b done=%b exp D=%h 0 0",
                 k, a.D, a.busy, a.done, POL);
      end
    end
  endtask

  initial begin
    a.V = 1'b0;
    a.Y = 3'd0;
    z.V = 1'b0;
    z.Y = 3'd0;
    rst = 1'b1;
    #12;
    total++;
    if (a.D !== POL || a.ready !== 1'b1 || a.busy !== 1'b0 ||
        a.done !== 1'b0 || z.D !== POL) begin
      bad++;
      $display("FAIL init D=%h rdy=%b busy=%b done=%b zD=%h exp D=%h 1 0 0",
               a.D, a.ready, a.busy, a.done, z.D, POL);
    end
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_zero_gap();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
